// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and coordinate type.
// Imported by the timing generator and the board renderer.
package vga_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One VGA axis: wrap counter plus registered sync and visible decodes.
// Decodes are taken from the next count so they align with cnt.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int SYNC_START = H_ACTIVE + H_FP,
    parameter int SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1,
    parameter int ACTIVE     = H_ACTIVE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               inc,
    output logic [COORD_W-1:0] cnt,
    output logic               wrap,
    output logic               sync_n,
    output logic               vis
);

    localparam coord_t LAST = to_coord(TOTAL - 1);
    localparam coord_t S0   = to_coord(SYNC_START);
    localparam coord_t S1   = to_coord(SYNC_END);
    localparam coord_t ACT  = to_coord(ACTIVE);

    logic [COORD_W-1:0] cnt_q;
    logic [COORD_W-1:0] cnt_d;
    logic               sync_n_q;
    logic               sync_n_d;
    logic               vis_q;
    logic               vis_d;

    // Next count (wrap on compare) and the decodes of that next count
    always_comb begin
        cnt_d = cnt_q;
        if (en && inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        sync_n_d = !((cnt_d >= S0) && (cnt_d <= S1));
        vis_d    = (cnt_d < ACT);
    end

    // Count and decodes share one register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= LAST;
            sync_n_q <= 1'b1;
            vis_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sync_n_q <= sync_n_d;
            vis_q    <= vis_d;
        end
    end

    assign cnt    = cnt_q;
    assign wrap   = (cnt_q == LAST);
    assign sync_n = sync_n_q;
    assign vis    = vis_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 timing from the 25 MHz vgaHz level, on the 100 MHz clock.
// VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_H_FP     = H_FP,
    parameter int P_H_SYNC   = H_SYNC,
    parameter int P_H_BP     = H_BP,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_V_FP     = V_FP,
    parameter int P_V_SYNC   = V_SYNC,
    parameter int P_V_BP     = V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vga_clk,
    output logic               pix_tick,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt
`endif
);

    localparam int H_TOT = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int H_SS  = P_H_ACTIVE + P_H_FP;
    localparam int H_SE  = H_SS + P_H_SYNC - 1;
    localparam int V_TOT = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
    localparam int V_SS  = P_V_ACTIVE + P_V_FP;
    localparam int V_SE  = V_SS + P_V_SYNC - 1;

    logic vga_clk_q;
    logic pix_tick_q;
    logic pix_tick_d;
    logic frame_start_q;
    logic frame_start_d;
    logic h_wrap;
    logic v_wrap;
    logic h_vis;
    logic v_vis;
    logic v_en;

    // Rising edge of vgaHz and the (799,524)->(0,0) transition
    always_comb begin
        pix_tick_d    = vga_clk & ~vga_clk_q;
        frame_start_d = pix_tick_q & h_wrap & v_wrap;
    end

    // Edge detector state, pixel tick and frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_clk_q     <= 1'b1;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vga_clk_q     <= vga_clk;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign v_en = pix_tick_q & h_wrap;

    vga_axis_cnt #(
        .TOTAL      (H_TOT),
        .SYNC_START (H_SS),
        .SYNC_END   (H_SE),
        .ACTIVE     (P_H_ACTIVE)
    ) u_h (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pix_tick_q),
        .inc    (1'b1),
        .cnt    (hcount),
        .wrap   (h_wrap),
        .sync_n (hsync),
        .vis    (h_vis)
    );

    vga_axis_cnt #(
        .TOTAL      (V_TOT),
        .SYNC_START (V_SS),
        .SYNC_END   (V_SE),
        .ACTIVE     (P_V_ACTIVE)
    ) u_v (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (v_en),
        .inc    (1'b1),
        .cnt    (vcount),
        .wrap   (v_wrap),
        .sync_n (vsync),
        .vis    (v_vis)
    );

    assign pix_tick    = pix_tick_q;
    assign active      = h_vis & v_vis;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;
    logic [7:0] frame_cnt_d;

    // Frame count steps on the same edge that raises frame_start
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    // Frame counter not built in this configuration
`endif

endmodule
